// File: rtl/dmem_if.sv
// Request/response channel between the core's MEM stage and the data-memory responder.
interface dmem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic                  req_addrmode;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  busy;

  modport master (
    output req_valid, req_write, req_addrmode, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addrmode, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory: one request in flight, fixed LATENCY, word/byte lanes,
// misaligned word accesses flagged and suppressed.
module dmem_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int MEM_ADDR_BITS = 17,
  parameter int LATENCY       = 2
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int IDX_BITS = MEM_ADDR_BITS - 2;
  localparam int WORDS    = 1 << IDX_BITS;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                   r_state, w_next_state;
  logic [3:0]               r_cnt, w_next_cnt;
  logic                     r_write, r_mode;
  logic [MEM_ADDR_BITS-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic                     r_err;
  logic [DATA_WIDTH-1:0]    r_mem [WORDS];

  logic                     w_accept;
  logic [IDX_BITS-1:0]      w_wr_idx;
  logic                     w_wr_mis;
  logic                     w_commit;
  logic [DATA_WIDTH-1:0]    w_wr_word;
  logic [MEM_ADDR_BITS-1:0] w_rd_addr;
  logic                     w_rd_write, w_rd_mode, w_rd_mis;
  logic [DATA_WIDTH-1:0]    w_rd_word, w_rd_data;
  logic                     w_unused_addr_hi;

  assign w_unused_addr_hi = ^bus.req_addr[ADDR_WIDTH-1:MEM_ADDR_BITS];

  assign bus.req_ready  = (r_state != S_WAIT);
  assign bus.busy       = (r_state == S_WAIT);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign w_accept       = bus.req_valid & bus.req_ready;

  // NOTE: every always_comb assigns its outputs a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    unique case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          w_next_state = (LATENCY == 1) ? S_RESP : S_WAIT;
          w_next_cnt   = CNT_INIT;
        end else if (r_state == S_RESP) begin
          w_next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_next_state = S_RESP;
        else               w_next_cnt   = r_cnt - 4'd1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Store commits on the edge leaving RESP; merged word is also the bypass source.
  assign w_wr_idx = r_addr[MEM_ADDR_BITS-1:2];
  assign w_wr_mis = ~r_mode & (r_addr[1:0] != 2'b00);
  assign w_commit = (r_state == S_RESP) & r_write & ~w_wr_mis;

  always_comb begin
    w_wr_word = r_mem[w_wr_idx];
    if (r_mode) w_wr_word[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else        w_wr_word = r_wdata;
  end

  // With LATENCY=1 a request accepted in RESP is read on the commit edge, hence the bypass.
  assign w_rd_addr  = (r_state == S_WAIT) ? r_addr  : bus.req_addr[MEM_ADDR_BITS-1:0];
  assign w_rd_write = (r_state == S_WAIT) ? r_write : bus.req_write;
  assign w_rd_mode  = (r_state == S_WAIT) ? r_mode  : bus.req_addrmode;
  assign w_rd_mis   = ~w_rd_mode & (w_rd_addr[1:0] != 2'b00);
  assign w_rd_word  = (w_commit && (w_rd_addr[MEM_ADDR_BITS-1:2] == w_wr_idx))
                    ? w_wr_word : r_mem[w_rd_addr[MEM_ADDR_BITS-1:2]];

  always_comb begin
    w_rd_data = '0;
    if (!w_rd_mis && !w_rd_write) begin
      if (w_rd_mode) w_rd_data[7:0] = w_rd_word[{w_rd_addr[1:0], 3'b000} +: 8];
      else           w_rd_data      = w_rd_word;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_mode  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_accept) begin
        r_write <= bus.req_write;
        r_mode  <= bus.req_addrmode;
        r_addr  <= bus.req_addr[MEM_ADDR_BITS-1:0];
        r_wdata <= bus.req_wdata;
      end
      if (w_next_state == S_RESP) begin
        r_rdata <= w_rd_data;
        r_err   <= w_rd_mis;
      end
    end
  end

  // NOTE: the RAM array has no reset; contents survive rst and only r_state gates commits.
  always_ff @(posedge clk) begin
    if (w_commit) r_mem[w_wr_idx] <= w_wr_word;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: DUT A with LATENCY=2, DUT B with LATENCY=1, shared stimulus fields.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        va, vb, t_write, t_mode;
  logic [31:0] t_addr, t_wdata;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  dmem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifa ();
  dmem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifb ();

  assign ifa.req_valid = va;      assign ifb.req_valid = vb;
  assign ifa.req_write = t_write; assign ifb.req_write = t_write;
  assign ifa.req_addrmode = t_mode;  assign ifb.req_addrmode = t_mode;
  assign ifa.req_addr  = t_addr;  assign ifb.req_addr  = t_addr;
  assign ifa.req_wdata = t_wdata; assign ifb.req_wdata = t_wdata;

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_ADDR_BITS(17), .LATENCY(2))
    u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_ADDR_BITS(17), .LATENCY(1))
    u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request from a negedge, returns at the negedge after the response cycle.
  task automatic run(input bit sel, input logic w, input logic m, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                     input string tag);
    int          lat;
    bit          got;
    logic [31:0] rd;
    logic        er, busy1, rdy1, after;
    t_write = w; t_mode = m; t_addr = a; t_wdata = d;
    if (sel) vb = 1'b1; else va = 1'b1;
    @(posedge clk); #1;
    va = 1'b0; vb = 1'b0;
    lat = 0; got = 1'b0; rd = '0; er = 1'b0; busy1 = 1'b0; rdy1 = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        busy1 = sel ? ifb.busy : ifa.busy;
        rdy1  = sel ? ifb.req_ready : ifa.req_ready;
      end
      if (sel ? ifb.resp_valid : ifa.resp_valid) begin
        got = 1'b1;
        rd  = sel ? ifb.resp_rdata : ifa.resp_rdata;
        er  = sel ? ifb.resp_err : ifa.resp_err;
      end
    end
    @(negedge clk);
    after = sel ? ifb.resp_valid : ifa.resp_valid;
    check({tag, "_lat"},   32'(lat), sel ? 32'd1 : 32'd2);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"},   {31'd0, er}, {31'd0, exp_err});
    check({tag, "_pulse"}, {31'd0, after}, 32'd0);
    check({tag, "_busy1"}, {31'd0, busy1}, sel ? 32'd0 : 32'd1);
    check({tag, "_rdy1"},  {31'd0, rdy1},  sel ? 32'd1 : 32'd0);
  endtask

  initial begin
    int          first, second, pulses;
    logic [31:0] rd2;
    rst = 1'b0; va = 1'b0; vb = 1'b0;
    t_write = 1'b0; t_mode = 1'b0; t_addr = '0; t_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, ifa.req_ready}, 32'd1);
    check("rst_valid", {31'd0, ifa.resp_valid}, 32'd0);
    check("rst_busy",  {31'd0, ifa.busy}, 32'd0);
    check("rst_rdata", ifa.resp_rdata, 32'd0);
    check("rst_err",   {31'd0, ifa.resp_err}, 32'd0);

    // Word store/load, byte lanes, misalignment on the LATENCY=2 unit.
    run(0, 1, 0, 32'h100, 32'hDEADBEEF, 32'h0,        0, "st_w100");
    run(0, 0, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, "ld_w100");
    run(0, 1, 1, 32'h101, 32'hFFFFFFA5, 32'h0,        0, "st_b101");
    run(0, 0, 0, 32'h100, 32'h0,        32'hDEADA5EF, 0, "ld_w100b");
    run(0, 0, 1, 32'h103, 32'h0,        32'h000000DE, 0, "ld_b103");
    run(0, 0, 0, 32'h102, 32'h0,        32'h0,        1, "ld_mis102");
    run(0, 1, 0, 32'h102, 32'h12345678, 32'h0,        1, "st_mis102");
    run(0, 0, 0, 32'h100, 32'h0,        32'hDEADA5EF, 0, "ld_after_mis");

    // Back-to-back: store held, then load accepted in the RESP cycle.
    t_write = 1'b1; t_mode = 1'b0; t_addr = 32'h200; t_wdata = 32'h11111111; va = 1'b1;
    @(posedge clk); #1;
    t_write = 1'b0; t_wdata = 32'h0;
    first = -1; second = -1; rd2 = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) check("b2b_ready_wait1", {31'd0, ifa.req_ready}, 32'd0);
      if (k == 3) check("b2b_ready_wait2", {31'd0, ifa.req_ready}, 32'd0);
      if (ifa.resp_valid) begin
        if (first < 0) begin
          first = k;
          check("b2b_st_err", {31'd0, ifa.resp_err}, 32'd0);
        end else if (second < 0) begin
          second = k;
          rd2 = ifa.resp_rdata;
        end
      end
      if (k == 2) begin
        @(posedge clk); #1;
        va = 1'b0;
      end
    end
    check("b2b_first",  32'(first), 32'd2);
    check("b2b_gap",    32'(second - first), 32'd2);
    check("b2b_rdata",  rd2, 32'h11111111);

    // Reset during WAIT discards the in-flight store.
    run(0, 1, 0, 32'h300, 32'h0, 32'h0, 0, "st_zero300");
    t_write = 1'b1; t_mode = 1'b0; t_addr = 32'h300; t_wdata = 32'hCAFEF00D; va = 1'b1;
    @(posedge clk); #1;
    va = 1'b0;
    @(negedge clk);
    check("mid_busy_wait", {31'd0, ifa.busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy",  {31'd0, ifa.busy}, 32'd0);
    check("mid_rst_valid", {31'd0, ifa.resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ifa.resp_valid) pulses++;
    end
    check("mid_no_pulse", 32'(pulses), 32'd0);
    check("mid_ready",    {31'd0, ifa.req_ready}, 32'd1);
    check("mid_busy",     {31'd0, ifa.busy}, 32'd0);
    run(0, 0, 0, 32'h300, 32'h0, 32'h0, 0, "ld_300");

    // LATENCY=1 unit: address wrap and store-to-load bypass.
    run(1, 1, 0, 32'h00020100, 32'h0BADC0DE, 32'h0,        0, "b_st_wrap");
    run(1, 0, 0, 32'h00000100, 32'h0,        32'h0BADC0DE, 0, "b_ld_100");
    t_write = 1'b1; t_mode = 1'b0; t_addr = 32'h104; t_wdata = 32'h55667788; vb = 1'b1;
    @(posedge clk); #1;
    t_write = 1'b0; t_wdata = 32'h0;
    @(negedge clk);
    check("b_b2b_first", {31'd0, ifb.resp_valid}, 32'd1);
    @(posedge clk); #1;
    vb = 1'b0;
    @(negedge clk);
    check("b_b2b_second", {31'd0, ifb.resp_valid}, 32'd1);
    check("b_b2b_rdata",  ifb.resp_rdata, 32'h55667788);
    @(negedge clk);
    check("b_b2b_idle",   {31'd0, ifb.resp_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder answering the core's load/store requests over a valid/ready request channel and a single-pulse response channel. It replaces the single-cycle combinational data memory so the pipeline's MEM stage can stall on memory latency. It holds the data RAM array, performs word/byte lane selection and flags misaligned word accesses. One request in flight at a time.

Parameters:
DATA_WIDTH, 32, data width; fixed at 32 (4 byte lanes)
ADDR_WIDTH, 32, request byte-address width
MEM_ADDR_BITS, 17, byte-address bits decoded (array = 2^MEM_ADDR_BITS bytes); upper address bits ignored (wrap-around)
LATENCY, 2, edges from acceptance to response; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (rst=0 resets)
req_valid  in  1  request present
req_ready  out  1  responder can accept this cycle
req_write  in  1  1=store, 0=load
req_addrmode  in  1  1=byte access, 0=word access
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data (byte mode uses bits [7:0])
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  DATA_WIDTH  load data (0 for stores/errors)
resp_err  out  1  misaligned word access, qualified by resp_valid
busy  out  1  request in flight (state != IDLE and not RESP); pipeline stall source

Behaviour:
- States IDLE, WAIT, RESP. Down-counter cnt (4 bits).
- Reset (rst=0, async): state=IDLE, cnt=0, req_ready=1 after release, resp_valid=0, resp_rdata=0, resp_err=0, busy=0; captured request cleared; in-flight store discarded. RAM contents NOT cleared.
- req_ready = 1 in IDLE and RESP, 0 in WAIT (combinational from state).
- Acceptance: req_valid & req_ready at a rising edge; captures write, addrmode, addr, wdata.
- On acceptance: LATENCY=1 -> RESP; else WAIT with cnt=LATENCY-2.
- WAIT: cnt==0 -> RESP at next edge, else cnt decrements.
- RESP lasts exactly one cycle; resp_valid=1 only in RESP. No response back-pressure.
- RESP exit: acceptance in same cycle -> WAIT/RESP per LATENCY rule (back-to-back, one request per LATENCY cycles); else IDLE.
- resp_valid asserted in the cycle following the LATENCY-th rising edge, counting the acceptance edge as the first.
- Load data registered on the edge entering RESP: word mode -> word at addr[MEM_ADDR_BITS-1:2]; byte mode -> byte at lane addr[1:0] (little-endian), zero-extended.
- Store commits on the edge leaving RESP: word mode writes all 4 lanes; byte mode writes only lane addr[1:0] with wdata[7:0]. A load accepted on that same edge observes the committed store.
- Misaligned: word mode with addr[1:0]!=0 -> resp_err=1, resp_rdata=0, store suppressed. Byte mode never errors.
- resp_rdata=0 and resp_err=0 for aligned stores; resp_rdata/resp_err hold last value outside RESP but are qualified by resp_valid only.
- busy=1 in WAIT only.
- Reset asserted in WAIT or RESP: no response pulse, no store commit, returns IDLE.
- req_valid while req_ready=0: ignored, not queued; requester holds it.

Test Plan:
- LATENCY=2: store word 0xDEADBEEF @0x100 accepted edge E0 -> resp_valid high only in cycle after E1, err=0; then load @0x100 -> resp_rdata=0xDEADBEEF.
- Byte store 0xA5 @0x101, then word load @0x100 -> 0xDEADA5EF; byte load @0x103 -> 0x000000DE.
- Word load @0x102 -> resp_err=1, resp_rdata=0; word store 0x12345678 @0x102 -> resp_err=1, word @0x100 unchanged (0xDEADA5EF).
- Back-to-back: req_valid held with store 0x11111111 @0x200 then load @0x200 accepted in RESP cycle -> second resp_valid exactly 2 cycles after first, rdata=0x11111111; req_ready=0 in WAIT cycles.
- Reset mid-op: store 0xCAFEF00D @0x300 then rst=0 during WAIT -> no resp_valid, busy=0, req_ready=1 after release; load @0x300 returns prior contents (0x00000000 if pre-zeroed by bench).
- Wrap/LATENCY=1: store 0x0BADC0DE @(0x100 + 2^MEM_ADDR_BITS), load @0x100 -> 0x0BADC0DE; resp_valid in cycle immediately after acceptance edge.
